mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 199 +++++++++++++++++++
 tb/tb_mc_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: FSM sequencing, ALU decode, condition
// evaluation and the stored NZCV flags that gate architectural writes.
module mc_controller #(
  parameter int unsigned ALUCTRL_W = 4,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_flags;
  logic       r_condexr;

  logic       w_condex;
  logic [1:0] w_flagw;
  logic       w_nextpc;
  logic       w_regw;
  logic       w_memw;
  logic       w_branch;
  logic       w_exec;
  logic       w_nowrite;
  logic       w_pcs;
  logic [1:0] w_alu;

  logic [1:0] w_dp_op;
  logic       w_dp_nowrite;
  logic       w_dp_arith;
  logic       w_dp_valid;

  always_comb begin
    w_dp_op      = 2'd0;
    w_dp_nowrite = 1'b1;
    w_dp_arith   = 1'b0;
    w_dp_valid   = 1'b0;
    case (Funct[4:1])
      4'b0100: begin w_dp_op = 2'd0; w_dp_nowrite = 1'b0; w_dp_arith = 1'b1; w_dp_valid = 1'b1; end
      4'b0010: begin w_dp_op = 2'd1; w_dp_nowrite = 1'b0; w_dp_arith = 1'b1; w_dp_valid = 1'b1; end
      4'b0000: begin w_dp_op = 2'd2; w_dp_nowrite = 1'b0; w_dp_valid = 1'b1; end
      4'b1100: begin w_dp_op = 2'd3; w_dp_nowrite = 1'b0; w_dp_valid = 1'b1; end
      4'b1010: begin w_dp_op = 2'd1; w_dp_arith = 1'b1; w_dp_valid = 1'b1; end
      default: ;
    endcase
  end

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condex = 1'b0;
    case (Cond)
      4'b0000: w_condex = w_z;
      4'b0001: w_condex = ~w_z;
      4'b0010: w_condex = w_c;
      4'b0011: w_condex = ~w_c;
      4'b0100: w_condex = w_n;
      4'b0101: w_condex = ~w_n;
      4'b0110: w_condex = w_v;
      4'b0111: w_condex = ~w_v;
      4'b1000: w_condex = w_c & ~w_z;
      4'b1001: w_condex = ~w_c | w_z;
      4'b1010: w_condex = (w_n == w_v);
      4'b1011: w_condex = (w_n != w_v);
      4'b1100: w_condex = ~w_z & (w_n == w_v);
      4'b1101: w_condex = w_z | (w_n != w_v);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_flags   <= FLAGS_RST;
      r_condexr <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_condexr <= w_condex;
      if (w_flagw[1] && w_condex) r_flags[3:2] <= ALUFlags[3:2];
      if (w_flagw[0] && w_condex) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    w_nextpc  = 1'b0;
    w_regw    = 1'b0;
    w_memw    = 1'b0;
    w_branch  = 1'b0;
    w_exec    = 1'b0;
    w_alu     = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_next    = S_DECODE;
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_nextpc  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next  = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      S_EXECR: begin
        w_exec = 1'b1;
        w_alu  = w_dp_op;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB = 2'b01;
        w_exec  = 1'b1;
        w_alu   = w_dp_op;
        w_next  = S_ALUWB;
      end
      S_ALUWB: w_regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // NoWrite must still hold in ALUWB (where the register write happens) but
  // never leaks into MEMWB, whose Funct bits are not a data-processing cmd.
  assign w_nowrite = (w_exec || (r_state == S_ALUWB)) && w_dp_nowrite;
  assign w_flagw   = {w_exec & Funct[0] & w_dp_valid, w_exec & Funct[0] & w_dp_arith};
  assign w_pcs     = ((Rd == 4'b1111) && w_regw) || w_branch;

  assign PCWrite    = w_nextpc | (w_pcs & r_condexr);
  assign RegWrite   = w_regw & r_condexr & ~w_nowrite;
  assign MemWrite   = w_memw & r_condexr;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01) && !Funct[0], Op == 2'b10};
  assign ALUControl = ALUCTRL_W'(w_alu);
  assign State      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each driven cycle queues the expected
// outputs, and a negedge checker pops and compares them against the DUT.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [3:0] t_cond, t_rd, t_fl;
  logic [1:0] t_op;
  logic [5:0] t_funct;

  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [3:0] ALUControl, State;

  mc_controller #(.ALUCTRL_W(4), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .Cond(t_cond), .Op(t_op), .Funct(t_funct),
    .Rd(t_rd), .ALUFlags(t_fl), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .State(State)
  );

  typedef struct {
    logic [3:0] st;
    logic       pcw, memw, regw, irw, adr, srca;
    logic [1:0] res, srcb, imm, regsrc;
    logic [3:0] alu;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Per-state select values straight from the state output table.
  function automatic exp_t mk(input logic [3:0] st, input logic pcw, input logic memw,
                              input logic regw, input logic [3:0] alu);
    exp_t e;
    e.st     = st;
    e.pcw    = pcw;
    e.memw   = memw;
    e.regw   = regw;
    e.alu    = alu;
    e.irw    = (st == 4'd0);
    e.adr    = (st == 4'd3) || (st == 4'd5);
    e.srca   = (st == 4'd0) || (st == 4'd1);
    e.res    = (st == 4'd0 || st == 4'd1 || st == 4'd9) ? 2'b10 : (st == 4'd4) ? 2'b01 : 2'b00;
    e.srcb   = (st == 4'd0 || st == 4'd1) ? 2'b10 :
               (st == 4'd2 || st == 4'd7 || st == 4'd9) ? 2'b01 : 2'b00;
    e.imm    = t_op;
    e.regsrc = {(t_op == 2'b01) && !t_funct[0], t_op == 2'b10};
    return e;
  endfunction

  function automatic void dp_ref(input logic [3:0] cmd, output logic [3:0] code, output logic wr);
    case (cmd)
      4'b0100: begin code = 4'd0; wr = 1'b1; end
      4'b0010: begin code = 4'd1; wr = 1'b1; end
      4'b0000: begin code = 4'd2; wr = 1'b1; end
      4'b1100: begin code = 4'd3; wr = 1'b1; end
      4'b1010: begin code = 4'd1; wr = 1'b0; end
      default: begin code = 4'd0; wr = 1'b0; end
    endcase
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_cyc++;
      check_eq($sformatf("c%0d.State", n_cyc),      State,      e.st);
      check_eq($sformatf("c%0d.PCWrite", n_cyc),    PCWrite,    e.pcw);
      check_eq($sformatf("c%0d.MemWrite", n_cyc),   MemWrite,   e.memw);
      check_eq($sformatf("c%0d.RegWrite", n_cyc),   RegWrite,   e.regw);
      check_eq($sformatf("c%0d.IRWrite", n_cyc),    IRWrite,    e.irw);
      check_eq($sformatf("c%0d.AdrSrc", n_cyc),     AdrSrc,     e.adr);
      check_eq($sformatf("c%0d.ALUSrcA", n_cyc),    ALUSrcA,    e.srca);
      check_eq($sformatf("c%0d.ResultSrc", n_cyc),  ResultSrc,  e.res);
      check_eq($sformatf("c%0d.ALUSrcB", n_cyc),    ALUSrcB,    e.srcb);
      check_eq($sformatf("c%0d.ImmSrc", n_cyc),     ImmSrc,     e.imm);
      check_eq($sformatf("c%0d.RegSrc", n_cyc),     RegSrc,     e.regsrc);
      check_eq($sformatf("c%0d.ALUControl", n_cyc), ALUControl, e.alu);
    end
  end

  task automatic step(input exp_t e);
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  // One full instruction starting at FETCH; ex is the hand-derived outcome
  // of the condition against the flags held before this instruction.
  task automatic do_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                          input logic [3:0] rd, input logic [3:0] fl, input logic ex);
    logic [3:0] code;
    logic       wr;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    t_cond  = cond;
    t_op    = op;
    t_funct = funct;
    t_rd    = rd;
    t_fl    = fl;
    q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 4'd0));
    step(mk(4'd1, 1'b0, 1'b0, 1'b0, 4'd0));
    case (op)
      2'b01: begin
        step(mk(4'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        if (funct[0]) begin
          step(mk(4'd3, 1'b0, 1'b0, 1'b0, 4'd0));
          step(mk(4'd4, 1'b0, 1'b0, ex, 4'd0));
        end else begin
          step(mk(4'd5, 1'b0, ex, 1'b0, 4'd0));
        end
      end
      2'b00: begin
        dp_ref(funct[4:1], code, wr);
        step(mk(funct[5] ? 4'd7 : 4'd6, 1'b0, 1'b0, 1'b0, code));
        step(mk(4'd8, ex && (rd == 4'hF), 1'b0, ex && wr, 4'd0));
      end
      2'b10: step(mk(4'd9, ex, 1'b0, 1'b0, 4'd0));
      default: ;
    endcase
  endtask

  initial begin
    reset   = 1'b1;
    t_cond  = 4'h0;
    t_op    = 2'b00;
    t_funct = 6'b0;
    t_rd    = 4'h0;
    t_fl    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    //        cond   op     funct      rd     ALUFlags ex
    do_instr(4'hE, 2'b00, 6'b001001, 4'd1,  4'b0100, 1'b1); // ADDS -> Z=1
    do_instr(4'h0, 2'b00, 6'b001000, 4'd2,  4'b0000, 1'b1); // ADDEQ taken
    do_instr(4'hE, 2'b00, 6'b010101, 4'd0,  4'b0000, 1'b1); // CMP -> flags 0000
    do_instr(4'h0, 2'b00, 6'b001000, 4'd2,  4'b0000, 1'b0); // ADDEQ skipped
    do_instr(4'hE, 2'b00, 6'b011011, 4'd3,  4'b0100, 1'b1); // unsupported cmd, S=1
    do_instr(4'h0, 2'b00, 6'b001000, 4'd2,  4'b0000, 1'b0); // Z still 0
    do_instr(4'hE, 2'b00, 6'b010101, 4'd0,  4'b0100, 1'b1); // CMP -> Z=1
    do_instr(4'h0, 2'b00, 6'b001000, 4'd2,  4'b0000, 1'b1); // ADDEQ taken
    do_instr(4'hE, 2'b00, 6'b100101, 4'd4,  4'b1000, 1'b1); // SUBS imm -> 1000
    do_instr(4'h4, 2'b00, 6'b011000, 4'd5,  4'b0000, 1'b1); // ORRMI taken
    do_instr(4'hA, 2'b00, 6'b000000, 4'd6,  4'b0000, 1'b0); // ANDGE skipped
    do_instr(4'hE, 2'b00, 6'b001001, 4'd1,  4'b0011, 1'b1); // ADDS -> 0011
    do_instr(4'h8, 2'b00, 6'b001000, 4'd1,  4'b0000, 1'b1); // ADDHI taken
    do_instr(4'hE, 2'b00, 6'b000001, 4'd1,  4'b1100, 1'b1); // ANDS -> 1111 (CV kept)
    do_instr(4'hC, 2'b00, 6'b001000, 4'd1,  4'b0000, 1'b0); // ADDGT skipped
    do_instr(4'hA, 2'b00, 6'b001000, 4'd1,  4'b0000, 1'b1); // ADDGE taken
    do_instr(4'hE, 2'b01, 6'b011001, 4'd0,  4'b0000, 1'b1); // LDR
    do_instr(4'hE, 2'b01, 6'b011000, 4'd0,  4'b0000, 1'b1); // STR
    do_instr(4'h1, 2'b01, 6'b011000, 4'd0,  4'b0000, 1'b0); // STRNE skipped
    do_instr(4'hE, 2'b10, 6'b100000, 4'd0,  4'b0000, 1'b1); // B
    do_instr(4'hF, 2'b10, 6'b100000, 4'd0,  4'b0000, 1'b0); // B never
    do_instr(4'hE, 2'b00, 6'b001000, 4'hF,  4'b0000, 1'b1); // ADD PC
    do_instr(4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 1'b1); // illegal Op

    // STR aborted by reset raised during MEMADR
    @(posedge clk);
    #1;
    t_cond  = 4'hE;
    t_op    = 2'b01;
    t_funct = 6'b011000;
    t_rd    = 4'd0;
    q.push_back(mk(4'd0, 1'b1, 1'b0, 1'b0, 4'd0));
    step(mk(4'd1, 1'b0, 1'b0, 1'b0, 4'd0));
    step(mk(4'd2, 1'b0, 1'b0, 1'b0, 4'd0));
    reset = 1'b1;
    do_instr(4'h0, 2'b00, 6'b001000, 4'd1,  4'b0000, 1'b0); // flags back to 0000
    do_instr(4'h1, 2'b00, 6'b001000, 4'd1,  4'b0000, 1'b1); // ADDNE taken

    @(posedge clk);
    #1;
    check_eq("sb_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
